// File: rtl/regop_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regop_pkg
// Description : Shared encodings for the register-operation sequencer:
//               target-register function selects and FSM states.
// Revision    : 1.0  initial release
// ============================================================================
package regop_pkg;

  // Target-register function select; also the command opcode.
  typedef enum logic [1:0] {
    OP_DEC   = 2'b00,
    OP_INC   = 2'b01,
    OP_LOAD  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage
`default_nettype wire

// File: rtl/reg_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : reg_op_sequencer
// Description : Accepts LOAD/CLEAR/INC/DEC commands and issues them to an
//               external target register as registered E/FunSel/I strobes.
//               INC/DEC repeat N times (abortable); a shadow copy of the
//               target register is kept alongside.
// Revision    : 1.0  initial release
// ============================================================================
module reg_op_sequencer
  import regop_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             CmdValid,
  output logic             CmdReady,
  input  logic [1:0]       CmdOp,
  input  logic [WIDTH-1:0] CmdData,
  input  logic [CNT_W-1:0] CmdCount,
  input  logic             Abort,
  output logic             E,
  output logic [1:0]       FunSel,
  output logic [WIDTH-1:0] I,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Shadow,
  output logic             ShadowValid
);

  state_e           r_state;
  state_e           w_state_nxt;
  logic             r_e;
  logic             w_e_nxt;
  logic [1:0]       r_funsel;
  logic [1:0]       w_funsel_nxt;
  logic [WIDTH-1:0] r_i;
  logic [WIDTH-1:0] w_i_nxt;
  // Number of E cycles still to issue after the current one.
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_shadow;
  logic             r_shadow_valid;
  op_e              w_op;

  assign w_op = op_e'(CmdOp);

  // State, strobe and counter registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state  <= ST_IDLE;
      r_e      <= 1'b0;
      r_funsel <= 2'b00;
      r_i      <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_e      <= w_e_nxt;
      r_funsel <= w_funsel_nxt;
      r_i      <= w_i_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  // Next state and next strobe values; strobes default to the idle pattern.
  always_comb begin
    w_state_nxt  = r_state;
    w_e_nxt      = 1'b0;
    w_funsel_nxt = 2'b00;
    w_i_nxt      = '0;
    w_cnt_nxt    = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (CmdValid) begin
          if (w_op == OP_LOAD || w_op == OP_CLEAR) begin
            w_state_nxt  = ST_ISSUE;
            w_e_nxt      = 1'b1;
            w_funsel_nxt = w_op;
            w_i_nxt      = (w_op == OP_LOAD) ? CmdData : '0;
            w_cnt_nxt    = '0;
          end else if (CmdCount == '0) begin
            // Zero-length burst: nothing to issue, report completion at once.
            w_state_nxt = ST_DONE;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt  = ST_ISSUE;
            w_e_nxt      = 1'b1;
            w_funsel_nxt = w_op;
            w_cnt_nxt    = CmdCount - CNT_W'(1);
          end
        end
      end
      ST_ISSUE: begin
        // The E cycle in progress always completes; abort only stops further ones.
        if (Abort || r_cnt == '0) begin
          w_state_nxt = ST_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_e_nxt      = 1'b1;
          w_funsel_nxt = r_funsel;
          w_i_nxt      = r_i;
          w_cnt_nxt    = r_cnt - CNT_W'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Shadow copy follows the target register on every edge it samples E=1.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_shadow       <= '0;
      r_shadow_valid <= 1'b0;
    end else if (r_e) begin
      case (r_funsel)
        OP_LOAD: begin
          r_shadow       <= r_i;
          r_shadow_valid <= 1'b1;
        end
        OP_CLEAR: begin
          r_shadow       <= '0;
          r_shadow_valid <= 1'b1;
        end
        OP_INC: if (r_shadow_valid) r_shadow <= r_shadow + WIDTH'(1);
        default: if (r_shadow_valid) r_shadow <= r_shadow - WIDTH'(1);
      endcase
    end
  end

  assign E           = r_e;
  assign FunSel      = r_funsel;
  assign I           = r_i;
  assign CmdReady    = (r_state == ST_IDLE);
  assign Busy        = (r_state != ST_IDLE);
  assign Done        = (r_state == ST_DONE);
  assign Shadow      = r_shadow;
  assign ShadowValid = r_shadow_valid;

endmodule
`default_nettype wire

// File: tb/tb_reg_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_op_sequencer
// Description : Self-checking bench for reg_op_sequencer: directed scenarios
//               followed by randomized commands against a reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_reg_op_sequencer;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  logic             Clock = 1'b0;
  logic             Reset;
  logic             CmdValid;
  logic             CmdReady;
  logic [1:0]       CmdOp;
  logic [WIDTH-1:0] CmdData;
  logic [CNT_W-1:0] CmdCount;
  logic             Abort;
  logic             E;
  logic [1:0]       FunSel;
  logic [WIDTH-1:0] I;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Shadow;
  logic             ShadowValid;

  int n_checks = 0;
  int n_errors = 0;

  // Command-level reference state.
  int m_shadow = 0;
  bit m_valid  = 1'b0;

  // Model of the external target register, driven by the issued strobes.
  logic [WIDTH-1:0] tgt_q;
  logic             tgt_v;

  reg_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .Clock(Clock), .Reset(Reset), .CmdValid(CmdValid), .CmdReady(CmdReady),
    .CmdOp(CmdOp), .CmdData(CmdData), .CmdCount(CmdCount), .Abort(Abort),
    .E(E), .FunSel(FunSel), .I(I), .Busy(Busy), .Done(Done),
    .Shadow(Shadow), .ShadowValid(ShadowValid)
  );

  always #5 Clock = ~Clock;

  // Target register: LOAD/CLEAR define it, INC/DEC only act once it is known.
  always @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      tgt_q <= '0;
      tgt_v <= 1'b0;
    end else if (E) begin
      case (FunSel)
        2'b10: begin tgt_q <= I;  tgt_v <= 1'b1; end
        2'b11: begin tgt_q <= '0; tgt_v <= 1'b1; end
        2'b01: if (tgt_v) tgt_q <= tgt_q + 16'd1;
        default: if (tgt_v) tgt_q <= tgt_q - 16'd1;
      endcase
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_e"},      E, 0);
    check_val({tag, "_funsel"}, FunSel, 0);
    check_val({tag, "_i"},      I, 0);
    check_val({tag, "_busy"},   Busy, 0);
    check_val({tag, "_done"},   Done, 0);
    check_val({tag, "_shadow"}, Shadow, 0);
    check_val({tag, "_svalid"}, ShadowValid, 0);
    check_val({tag, "_ready"},  CmdReady, 1);
  endtask

  // Issue one command and follow it cycle by cycle until Done.
  // abort_at = k > 0 raises Abort during the k-th E cycle of an INC/DEC burst.
  task automatic run_cmd(input logic [1:0] op, input logic [15:0] data, input int count,
                         input int abort_at, input bit hold);
    int  p;
    int  ecount;
    bit  seen_done;
    logic [15:0] exp_i;
    if (op >= 2'd2)                                p = 1;
    else if (abort_at != 0 && abort_at < count)    p = abort_at;
    else                                           p = count;
    exp_i = (op == 2'd2) ? data : 16'h0;

    @(negedge Clock);
    check_val("ready_before_cmd", CmdReady, 1);
    CmdValid = 1'b1;
    CmdOp    = op;
    CmdData  = data;
    CmdCount = CNT_W'(count);
    Abort    = 1'b0;

    ecount    = 0;
    seen_done = 1'b0;
    for (int c = 1; c <= count + 4 && !seen_done; c++) begin
      @(negedge Clock);
      check_val("e",        E, (c <= p) ? 1 : 0);
      check_val("funsel",   FunSel, (c <= p) ? 32'(op) : 0);
      check_val("i",        I, (c <= p) ? 32'(exp_i) : 0);
      check_val("done",     Done, (c == p + 1) ? 1 : 0);
      check_val("busy",     Busy, 1);
      check_val("ready",    CmdReady, 0);
      check_val("shadow_vs_tgt", Shadow, tgt_q);
      check_val("svalid_vs_tgt", ShadowValid, tgt_v);
      if (E) ecount++;
      // Scramble the command inputs: the sequencer must work from latched values.
      CmdOp    = 2'($urandom);
      CmdData  = 16'($urandom);
      CmdCount = CNT_W'($urandom);
      if (!hold) CmdValid = 1'b0;
      Abort = (op < 2'd2 && abort_at != 0 && E && ecount == abort_at);
      if (Done) begin
        seen_done = 1'b1;
        CmdValid  = 1'b0;
        Abort     = 1'($urandom_range(0, 1));
      end
    end
    check_val("done_seen", seen_done, 1);
    check_val("e_pulses", ecount, p);

    if (op == 2'd2) begin
      m_shadow = data; m_valid = 1'b1;
    end else if (op == 2'd3) begin
      m_shadow = 0; m_valid = 1'b1;
    end else if (m_valid) begin
      if (op == 2'd1) m_shadow = (m_shadow + p) % 65536;
      else            m_shadow = (m_shadow + 65536 - p) % 65536;
    end
    check_val("shadow_final", Shadow, m_shadow);
    check_val("svalid_final", ShadowValid, m_valid);

    @(negedge Clock);
    check_val("idle_busy",  Busy, 0);
    check_val("idle_ready", CmdReady, 1);
    check_val("idle_e",     E, 0);
    check_val("idle_done",  Done, 0);
    Abort = 1'($urandom_range(0, 1));
  endtask

  initial begin
    int op, cnt, ab;
    Reset    = 1'b0;
    CmdValid = 1'b0;
    CmdOp    = 2'b00;
    CmdData  = '0;
    CmdCount = '0;
    Abort    = 1'b0;
    #2;
    check_reset_outputs("reset");
    @(negedge Clock);
    Reset = 1'b1;

    // LOAD, INC wrap, CLEAR + DEC wrap, aborted DEC, zero-length INC held valid.
    run_cmd(2'd2, 16'h1234, 0, 0, 1'b0);
    run_cmd(2'd2, 16'hFFFE, 0, 0, 1'b0);
    run_cmd(2'd1, 16'h0000, 3, 0, 1'b0);
    run_cmd(2'd3, 16'hABCD, 0, 0, 1'b0);
    run_cmd(2'd0, 16'h0000, 1, 0, 1'b0);
    run_cmd(2'd2, 16'h0010, 0, 0, 1'b0);
    run_cmd(2'd0, 16'h0000, 10, 4, 1'b0);
    run_cmd(2'd1, 16'h5555, 0, 0, 1'b1);
    run_cmd(2'd1, 16'h0000, 4, 4, 1'b1);

    // Reset during the second E cycle of a 5-long INC burst.
    @(negedge Clock);
    CmdValid = 1'b1; CmdOp = 2'd1; CmdCount = 8'd5; Abort = 1'b0;
    @(negedge Clock);
    CmdValid = 1'b0;
    check_val("rst_burst_e1", E, 1);
    @(negedge Clock);
    check_val("rst_burst_e2", E, 1);
    #2 Reset = 1'b0;
    #1 check_reset_outputs("rst_mid");
    for (int k = 0; k < 3; k++) begin
      @(negedge Clock);
      check_val("rst_hold_done", Done, 0);
      check_val("rst_hold_e", E, 0);
    end
    Reset = 1'b1;
    m_shadow = 0;
    m_valid  = 1'b0;
    @(negedge Clock);
    check_reset_outputs("rst_release");

    // Randomized commands; early INC/DEC run on an unknown shadow.
    for (int n = 0; n < 40; n++) begin
      op  = $urandom_range(0, 3);
      cnt = $urandom_range(0, 6);
      ab  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, (cnt > 0) ? cnt : 1) : 0;
      run_cmd(2'(op), 16'($urandom), cnt, ab, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", n_errors, n_checks);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/reg_op_sequencer.md
REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, SHALL set the data width of the target register.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the repeat counter.
REQ-003 Clock  input  1  SHALL be the single clock; all state updates on rising edge.
REQ-004 Reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 CmdValid  input  1  SHALL signal that a command is presented.
REQ-006 CmdReady  output  1  SHALL signal that the sequencer accepts a command this cycle.
REQ-007 CmdOp  input  2  SHALL encode the operation: 00 DEC, 01 INC, 10 LOAD, 11 CLEAR.
REQ-008 CmdData  input  WIDTH  SHALL carry the load value; ignored for other ops.
REQ-009 CmdCount  input  CNT_W  SHALL carry the repeat count for INC/DEC; ignored for LOAD/CLEAR.
REQ-010 Abort  input  1  SHALL request early termination of an INC/DEC burst.
REQ-011 E  output  1  SHALL be the target-register enable.
REQ-012 FunSel  output  2  SHALL be the target-register function select, same encoding as CmdOp.
REQ-013 I  output  WIDTH  SHALL be the target-register load data.
REQ-014 Busy  output  1  SHALL be high in ISSUE and DONE.
REQ-015 Done  output  1  SHALL be a one-cycle completion pulse.
REQ-016 Shadow  output  WIDTH  SHALL mirror the target register value.
REQ-017 ShadowValid  output  1  SHALL indicate Shadow is known (after the first LOAD or CLEAR).

Function
REQ-018 The FSM SHALL have states IDLE, ISSUE and DONE; CmdReady SHALL be high only in IDLE.
REQ-019 Acceptance SHALL occur on a rising edge with CmdValid=1 and CmdReady=1; op, data and count are latched then.
REQ-020 For LOAD/CLEAR accepted at edge T, E SHALL be high with FunSel=op for exactly one cycle after T; Done SHALL pulse the cycle after that.
REQ-021 For INC/DEC with count N>0 accepted at edge T, E SHALL be high for exactly N consecutive cycles after T; Done SHALL pulse the following cycle.
REQ-022 For INC/DEC with N=0, E SHALL stay low and the FSM SHALL go straight to DONE.
REQ-023 E, FunSel and I SHALL be registered outputs; when E=0, FunSel SHALL be 00 and I SHALL be 0.
REQ-024 Shadow SHALL update on the same edge at which the target register samples E=1: Q-1, Q+1, load value, or 0, modulo 2^WIDTH.
REQ-025 Shadow SHALL wrap 0->2^WIDTH-1 on DEC and 2^WIDTH-1->0 on INC.
REQ-026 INC/DEC on an invalid Shadow SHALL still be issued; Shadow and ShadowValid SHALL remain unchanged.
REQ-027 Abort=1 sampled in ISSUE SHALL force E low from the next cycle and move the FSM to DONE; the issued E count is the number already issued.
REQ-028 Abort sampled in IDLE or DONE SHALL be ignored; Abort on the last ISSUE cycle SHALL NOT change the issued count.
REQ-029 DONE SHALL last exactly one cycle and SHALL return to IDLE; back-to-back commands SHALL therefore be separated by at least one idle cycle.
REQ-030 CmdValid held high during ISSUE or DONE SHALL NOT be accepted until IDLE.

Reset
REQ-031 Reset low SHALL immediately force the FSM to IDLE and drive E=0, FunSel=00, I=0, Busy=0, Done=0, Shadow=0, ShadowValid=0 and counter=0; CmdReady=1 once in IDLE.
REQ-032 Reset asserted mid-burst SHALL terminate the burst with no further E pulse and no Done pulse.

Structure
REQ-033 The FunSel encodings (DEC, INC, LOAD, CLEAR) and the FSM state encoding SHALL live in the shared package regop_pkg.
REQ-034 The block SHALL be a single module with no sub-modules; the repeat counter and shadow register are internal.

Verification
REQ-035 Test 1: LOAD 0x1234 -> one E cycle with FunSel=10, I=0x1234; Done next cycle; Shadow=0x1234; ShadowValid=1.
REQ-036 Test 2: after LOAD 0xFFFE, INC with N=3 -> three E cycles with FunSel=01; Shadow=0x0001 (wrap); Done one cycle after the last E.
REQ-037 Test 3: CLEAR, then DEC with N=1 -> Shadow=0xFFFF; bench target-register model matches Shadow every cycle.
REQ-038 Test 4: LOAD 0x0010, then DEC with N=10 and Abort on the 4th E cycle -> exactly 4 E pulses; Shadow=0x000C; Done pulses.
REQ-039 Test 5: INC with N=0 -> no E pulse; Done one cycle after acceptance; CmdValid held high during Busy is not accepted twice.
REQ-040 Test 6: Reset asserted during the 2nd cycle of an INC burst with N=5 -> E low immediately; no Done; all outputs at their reset values; CmdReady=1 after release.
